// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch -> id1 instruction queue.
// Entry layout: {pc[31:0], inst[31:0], in_ds}.
package inst_queue_pkg;

   localparam int IQ_ENTRY_W  = 65;
   localparam int IQ_DS_BIT   = 0;
   localparam int IQ_INST_LSB = 1;
   localparam int IQ_PC_LSB   = 33;

   localparam logic [1:0] ISSUE_NONE = 2'd0;
   localparam logic [1:0] ISSUE_ONE  = 2'd1;
   localparam logic [1:0] ISSUE_TWO  = 2'd2;

   function automatic logic [IQ_ENTRY_W-1:0] iq_pack(
      input logic [31:0] pc,
      input logic [31:0] inst,
      input logic        ds
   );
      return {pc, inst, ds};
   endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Instruction queue storage: 2 write ports, 2 asynchronous read ports.
// No reset; validity is tracked by the pointer logic in inst_queue.
module inst_queue_ram
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic                  clk,
   input  logic                  we_1,
   input  logic [PTR_W-1:0]      waddr_1,
   input  logic [IQ_ENTRY_W-1:0] wdata_1,
   input  logic                  we_2,
   input  logic [PTR_W-1:0]      waddr_2,
   input  logic [IQ_ENTRY_W-1:0] wdata_2,
   input  logic [PTR_W-1:0]      raddr_1,
   output logic [IQ_ENTRY_W-1:0] rdata_1,
   input  logic [PTR_W-1:0]      raddr_2,
   output logic [IQ_ENTRY_W-1:0] rdata_2
);

   logic [IQ_ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_1) mem[waddr_1] <= wdata_1;
      if (we_2) mem[waddr_2] <= wdata_2;
   end

   assign rdata_1 = mem[raddr_1];
   assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/inst_queue.sv
// Dual-write/dual-read circular instruction queue between fetch and id1.
// Optional perf counters enabled by defining INST_QUEUE_PERF_EN.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             exception_flush,
   input  logic             stall,
   input  logic             if_valid_1,
   input  logic             if_valid_2,
   input  logic [31:0]      if_pc_1,
   input  logic [31:0]      if_pc_2,
   input  logic [31:0]      if_inst_1,
   input  logic [31:0]      if_inst_2,
   input  logic             if_is_branch_1,
   input  logic             if_is_branch_2,
   input  logic [1:0]       issue_num,
   output logic             iq_valid_1,
   output logic             iq_valid_2,
   output logic [31:0]      iq_pc_1,
   output logic [31:0]      iq_pc_2,
   output logic [31:0]      iq_inst_1,
   output logic [31:0]      iq_inst_2,
   output logic             iq_in_delay_slot_1,
   output logic             iq_in_delay_slot_2,
   output logic [PTR_W:0]   iq_count,
   output logic             iq_full,
   output logic             iq_empty
`ifdef INST_QUEUE_PERF_EN
   ,
   output logic [31:0]      perf_empty_cycles,
   output logic [31:0]      perf_full_cycles
`endif
);

   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W:0]        count;
   logic                  last_wr_branch;
   logic                  flush_now;
   logic                  do_wr;
   logic                  any_wr;
   logic                  next_branch;
   logic [1:0]            issue_clamp;
   logic [1:0]            n_rd;
   logic [1:0]            n_wr;
   logic                  we_1;
   logic                  we_2;
   logic [IQ_ENTRY_W-1:0] wdata_1;
   logic [IQ_ENTRY_W-1:0] wdata_2;
   logic [IQ_ENTRY_W-1:0] rdata_1;
   logic [IQ_ENTRY_W-1:0] rdata_2;

   assign iq_full  = count > (PTR_W+1)'(DEPTH - 2);
   assign iq_empty = count == '0;
   assign iq_count = count;

   always_comb begin
      flush_now = exception_flush | (flush & ~stall);
      unique case (issue_num)
         ISSUE_NONE: issue_clamp = ISSUE_NONE;
         ISSUE_ONE:  issue_clamp = ISSUE_ONE;
         default:    issue_clamp = ISSUE_TWO;
      endcase
      n_rd = ISSUE_NONE;
      if (!stall) begin
         if (count < (PTR_W+1)'(issue_clamp)) n_rd = count[1:0];
         else n_rd = issue_clamp;
      end
      // full is judged on pre-pop occupancy
      do_wr  = ~rst & ~iq_full & ~flush_now;
      any_wr = do_wr & (if_valid_1 | if_valid_2);
      n_wr   = do_wr ? ({1'b0, if_valid_1} + {1'b0, if_valid_2}) : 2'd0;
      we_1   = any_wr;
      we_2   = do_wr & if_valid_1 & if_valid_2;
      if (if_valid_1)
         wdata_1 = iq_pack(if_pc_1, if_inst_1, last_wr_branch);
      else
         wdata_1 = iq_pack(if_pc_2, if_inst_2, last_wr_branch);
      wdata_2 = iq_pack(if_pc_2, if_inst_2, if_is_branch_1);
      next_branch = if_valid_2 ? if_is_branch_2 : if_is_branch_1;
   end

   always_ff @(posedge clk) begin
      if (rst || flush_now) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         last_wr_branch <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr + PTR_W'(n_rd);
         wr_ptr <= wr_ptr + PTR_W'(n_wr);
         count  <= count + (PTR_W+1)'(n_wr) - (PTR_W+1)'(n_rd);
         if (any_wr) last_wr_branch <= next_branch;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush_now && !stall)
         assert ((PTR_W+1)'(issue_clamp) <= count);
   end

   inst_queue_ram #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_ram (
      .clk     (clk),
      .we_1    (we_1),
      .waddr_1 (wr_ptr),
      .wdata_1 (wdata_1),
      .we_2    (we_2),
      .waddr_2 (wr_ptr + PTR_W'(1)),
      .wdata_2 (wdata_2),
      .raddr_1 (rd_ptr),
      .rdata_1 (rdata_1),
      .raddr_2 (rd_ptr + PTR_W'(1)),
      .rdata_2 (rdata_2)
   );

   assign iq_valid_1 = count >= (PTR_W+1)'(1);
   assign iq_valid_2 = count >= (PTR_W+1)'(2);

   assign iq_pc_1   = iq_valid_1 ? rdata_1[IQ_PC_LSB +: 32] : '0;
   assign iq_inst_1 = iq_valid_1 ? rdata_1[IQ_INST_LSB +: 32] : '0;
   assign iq_pc_2   = iq_valid_2 ? rdata_2[IQ_PC_LSB +: 32] : '0;
   assign iq_inst_2 = iq_valid_2 ? rdata_2[IQ_INST_LSB +: 32] : '0;

   assign iq_in_delay_slot_1 = iq_valid_1 & rdata_1[IQ_DS_BIT];
   assign iq_in_delay_slot_2 = iq_valid_2 & rdata_2[IQ_DS_BIT];

`ifdef INST_QUEUE_PERF_EN
   // saturating; only rst clears them, flushes do not
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_empty_cycles <= '0;
         perf_full_cycles  <= '0;
      end else begin
         if (iq_empty && !stall && perf_empty_cycles != '1)
            perf_empty_cycles <= perf_empty_cycles + 32'd1;
         if (iq_full && perf_full_cycles != '1)
            perf_full_cycles <= perf_full_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed scoreboard bench for inst_queue.
// Builds with or without INST_QUEUE_PERF_EN.
module tb_inst_queue;

   localparam logic [31:0] K = 32'h1357_9BDF;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        exception_flush;
   logic        stall;
   logic        if_valid_1;
   logic        if_valid_2;
   logic [31:0] if_pc_1;
   logic [31:0] if_pc_2;
   logic [31:0] if_inst_1;
   logic [31:0] if_inst_2;
   logic        if_is_branch_1;
   logic        if_is_branch_2;
   logic [1:0]  issue_num;
   logic        iq_valid_1;
   logic        iq_valid_2;
   logic [31:0] iq_pc_1;
   logic [31:0] iq_pc_2;
   logic [31:0] iq_inst_1;
   logic [31:0] iq_inst_2;
   logic        iq_in_delay_slot_1;
   logic        iq_in_delay_slot_2;
   logic [4:0]  iq_count;
   logic        iq_full;
   logic        iq_empty;
`ifdef INST_QUEUE_PERF_EN
   logic [31:0] perf_empty_cycles;
   logic [31:0] perf_full_cycles;
   logic [31:0] snap_e;
   logic [31:0] snap_f;
`endif

   always #5 clk = ~clk;

   inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .flush              (flush),
      .exception_flush    (exception_flush),
      .stall              (stall),
      .if_valid_1         (if_valid_1),
      .if_valid_2         (if_valid_2),
      .if_pc_1            (if_pc_1),
      .if_pc_2            (if_pc_2),
      .if_inst_1          (if_inst_1),
      .if_inst_2          (if_inst_2),
      .if_is_branch_1     (if_is_branch_1),
      .if_is_branch_2     (if_is_branch_2),
      .issue_num          (issue_num),
      .iq_valid_1         (iq_valid_1),
      .iq_valid_2         (iq_valid_2),
      .iq_pc_1            (iq_pc_1),
      .iq_pc_2            (iq_pc_2),
      .iq_inst_1          (iq_inst_1),
      .iq_inst_2          (iq_inst_2),
      .iq_in_delay_slot_1 (iq_in_delay_slot_1),
      .iq_in_delay_slot_2 (iq_in_delay_slot_2),
      .iq_count           (iq_count),
      .iq_full            (iq_full),
      .iq_empty           (iq_empty)
`ifdef INST_QUEUE_PERF_EN
      ,
      .perf_empty_cycles  (perf_empty_cycles),
      .perf_full_cycles   (perf_full_cycles)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        ds;
   } ent_t;

   ent_t        sb[$];
   logic        last_br;
   logic [31:0] pe_m;
   logic [31:0] pf_m;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      int n;
      n = sb.size();
      chk({tag, "_count"}, 64'(iq_count), 64'(n));
      chk({tag, "_v1"}, 64'(iq_valid_1), 64'(n >= 1));
      chk({tag, "_v2"}, 64'(iq_valid_2), 64'(n >= 2));
      chk({tag, "_empty"}, 64'(iq_empty), 64'(n == 0));
      chk({tag, "_full"}, 64'(iq_full), 64'(n > 14));
   endtask

   // Called at a negedge; checks popped heads, drives, advances one clock.
   task automatic cyc(
      input logic v1, input logic [31:0] p1, input logic b1,
      input logic v2, input logic [31:0] p2, input logic b2,
      input logic [1:0] iss, input logic st, input logic fl,
      input logic ef
   );
      int   n;
      int   ic;
      int   nr;
      ent_t e;
      n = sb.size();
      if (n == 0 && !st) pe_m++;
      if (n > 14) pf_m++;
      if (ef || (fl && !st)) begin
         sb.delete();
         last_br = 1'b0;
      end else begin
         ic = (iss == 2'd3) ? 2 : int'(iss);
         nr = st ? 0 : ((ic > n) ? n : ic);
         for (int i = 0; i < nr; i++) begin
            e = sb.pop_front();
            if (i == 0) begin
               chk("pop_pc1", 64'(iq_pc_1), 64'(e.pc));
               chk("pop_inst1", 64'(iq_inst_1), 64'(e.inst));
               chk("pop_ds1", 64'(iq_in_delay_slot_1), 64'(e.ds));
            end else begin
               chk("pop_pc2", 64'(iq_pc_2), 64'(e.pc));
               chk("pop_inst2", 64'(iq_inst_2), 64'(e.inst));
               chk("pop_ds2", 64'(iq_in_delay_slot_2), 64'(e.ds));
            end
         end
         if (n <= 14) begin
            if (v1) sb.push_back('{p1, p1 ^ K, last_br});
            if (v2) sb.push_back('{p2, p2 ^ K, v1 ? b1 : last_br});
            if (v2) last_br = b2;
            else if (v1) last_br = b1;
         end
      end
      if_valid_1      = v1;
      if_valid_2      = v2;
      if_pc_1         = p1;
      if_pc_2         = p2;
      if_inst_1       = p1 ^ K;
      if_inst_2       = p2 ^ K;
      if_is_branch_1  = b1;
      if_is_branch_2  = b2;
      issue_num       = iss;
      stall           = st;
      flush           = fl;
      exception_flush = ef;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push2(input logic [31:0] p, input logic b1,
                        input logic b2, input logic [1:0] iss);
      cyc(1'b1, p, b1, 1'b1, p + 32'd4, b2, iss, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      while (sb.size() > 0)
         cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0,
             (sb.size() >= 2) ? 2'd2 : 2'd1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      exception_flush = 1'b0;
      stall = 1'b0;
      if_valid_1 = 1'b0;
      if_valid_2 = 1'b0;
      if_pc_1 = '0;
      if_pc_2 = '0;
      if_inst_1 = '0;
      if_inst_2 = '0;
      if_is_branch_1 = 1'b0;
      if_is_branch_2 = 1'b0;
      issue_num = 2'd0;
      last_br = 1'b0;
      pe_m = '0;
      pf_m = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk_state("reset");
      chk("reset_pc1", 64'(iq_pc_1), 64'h0);
      chk("reset_ds1", 64'(iq_in_delay_slot_1), 64'h0);
`ifdef INST_QUEUE_PERF_EN
      chk("reset_perf_e", 64'(perf_empty_cycles), 64'h0);
      chk("reset_perf_f", 64'(perf_full_cycles), 64'h0);
`endif

      // basic pair push
      push2(32'hBFC0_0000, 1'b0, 1'b0, 2'd0);
      chk_state("pair");
      chk("pair_pc1", 64'(iq_pc_1), 64'hBFC0_0000);
      chk("pair_pc2", 64'(iq_pc_2), 64'hBFC0_0004);
      drain();

      // delay-slot flags
      push2(32'h100, 1'b1, 1'b0, 2'd0);
      cyc(1'b1, 32'h108, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("ds_104", 64'(iq_in_delay_slot_2), 64'h1);
      push2(32'h200, 1'b0, 1'b1, 2'd2);
      cyc(1'b1, 32'h208, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk_state("ds");
      drain();

      // only slot 2 valid: compacted to wr_ptr
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h600, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("v2only_pc1", 64'(iq_pc_1), 64'h600);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h604, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("v2only_ds2", 64'(iq_in_delay_slot_2), 64'h1);
      drain();

      // fill to 15
      for (int k = 0; k < 6; k++)
         push2(32'h2000 + 32'(8 * k), 1'b0, 1'b0, 2'd0);
      cyc(1'b1, 32'h2030, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk_state("pre_full");
      push2(32'h2034, 1'b0, 1'b0, 2'd0);
      chk_state("full");
      push2(32'h3000, 1'b1, 1'b1, 2'd0);
      chk_state("full_drop");
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
      chk_state("unfull");
      drain();

      // wrap-around, steady push 2 / pop 2
      push2(32'h1000, 1'b0, 1'b0, 2'd0);
      for (int k = 1; k <= 40; k++) begin
         push2(32'h1000 + 32'(8 * k), k[0], 1'b0, 2'd2);
         chk_state("wrap");
      end
      drain();

      // stall and flush interaction
      push2(32'h700, 1'b0, 1'b0, 2'd0);
      push2(32'h708, 1'b0, 1'b0, 2'd0);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
      chk_state("stall");
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
      chk_state("stall_flush");
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
      chk_state("flush");

      // exception flush beats stall, pushes and pops
      push2(32'h300, 1'b1, 1'b1, 2'd0);
`ifdef INST_QUEUE_PERF_EN
      snap_e = perf_empty_cycles;
      snap_f = perf_full_cycles;
`endif
      push2(32'h500, 1'b0, 1'b0, 2'd1);
      cyc(1'b1, 32'h500, 1'b0, 1'b1, 32'h504, 1'b0, 2'd1,
          1'b1, 1'b0, 1'b1);
      chk_state("exc");
      chk("exc_pc1", 64'(iq_pc_1), 64'h0);
`ifdef INST_QUEUE_PERF_EN
      chk("exc_perf_f", 64'(perf_full_cycles), 64'(snap_f));
      chk("exc_perf_e", 64'(perf_empty_cycles), 64'(snap_e));
`endif
      cyc(1'b1, 32'h400, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("exc_ds", 64'(iq_in_delay_slot_1), 64'h0);
      drain();

      // issue_num 3 behaves as 2
      push2(32'h800, 1'b0, 1'b0, 2'd0);
      push2(32'h808, 1'b0, 1'b0, 2'd0);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
      chk_state("iss3");
      drain();
      chk_state("end");

`ifdef INST_QUEUE_PERF_EN
      chk("perf_empty", 64'(perf_empty_cycles), 64'(pe_m));
      chk("perf_full", 64'(perf_full_cycles), 64'(pf_m));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Dual-write/dual-read circular instruction buffer between fetch and id1 in the dual-issue pipeline.
- Fetch pushes 0–2 instructions per cycle; issue pops 0–2 per cycle from the head.
- Head entries feed the id1 decode/issue logic, which in turn drives the id1→id2 pipeline register.
- Generates the per-entry in-delay-slot flag and the backpressure (full) signal to fetch.

Parameters:
- DEPTH, 16, number of entries; power of two, ≥4.
- PTR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  branch-mispredict flush; honoured only when stall=0.
- exception_flush  in  1  unconditional flush.
- stall  in  1  back-end stall; freezes the read side.
- if_valid_1  in  1  write slot 1 valid.
- if_valid_2  in  1  write slot 2 valid.
- if_pc_1, if_pc_2  in  32  PCs of the write slots.
- if_inst_1, if_inst_2  in  32  instruction words.
- if_is_branch_1, if_is_branch_2  in  1  instruction is a branch/jump (pre-decoded).
- issue_num  in  2  entries consumed this cycle (0, 1, 2; 3 is treated as 2).
- iq_valid_1, iq_valid_2  out  1  head / head+1 entry valid.
- iq_pc_1, iq_pc_2  out  32  head entry PCs.
- iq_inst_1, iq_inst_2  out  32  head entry instructions.
- iq_in_delay_slot_1, iq_in_delay_slot_2  out  1  entry follows a branch.
- iq_count  out  PTR_W+1  occupancy.
- iq_full  out  1  fewer than 2 free slots; fetch must hold.
- iq_empty  out  1  count==0.

Behaviour:
- Reset: rd_ptr=wr_ptr=0, count=0, last_wr_branch=0. iq_valid_*=0, iq_count=0, iq_empty=1, iq_full=0. Entry storage is not reset. iq_pc/inst/in_delay_slot outputs are forced to 0 whenever the matching valid is 0.
- Read side is combinational from storage: iq_valid_1 = count≥1; iq_valid_2 = count≥2. Entries are at rd_ptr and rd_ptr+1, modulo DEPTH.
- Write-to-read latency is 1 cycle. There is no bypass, so an empty queue shows iq_valid_1=0 on the push cycle.
- Write acceptance:
  - Writes are accepted only when iq_full=0, using pre-pop occupancy.
  - When full, both slots are dropped and fetch is responsible for holding.
  - Valid slots are compacted in order. If only if_valid_2 is set, it is written at wr_ptr as a single entry.
  - Pushes per cycle: n_wr = if_valid_1 + if_valid_2.
- Delay-slot flag:
  - Each written entry stores in_ds = is_branch of the previously written instruction.
  - For slot 2 when both are valid, that is if_is_branch_1. Otherwise it is last_wr_branch.
  - last_wr_branch updates to the branch flag of the last entry written this cycle.
- Pop:
  - Pops per cycle: n_rd = stall ? 0 : min(issue_num clamped to 2, count).
  - issue_num greater than count is clamped; an assertion fires in simulation.
- Update: rd_ptr += n_rd; wr_ptr += n_wr; count += n_wr − n_rd. All pointer arithmetic is modulo DEPTH (natural PTR_W wrap).
- Simultaneous push and pop in the same cycle is allowed.
- iq_full = (count > DEPTH−2), registered-state based.
- Flush priority, highest first: rst > exception_flush > (flush & !stall) > normal.
  - A flush cycle resets pointers, count and last_wr_branch, and drops same-cycle writes and pops.
  - flush with stall=1 has no effect that cycle; the requester holds flush until stall drops.
- Reset or flush mid-operation discards all entries with no partial drain.

Optional Feature:
- Macro: INST_QUEUE_PERF_EN.
- When defined, add outputs:
  - perf_empty_cycles (32): increments on every cycle with count==0 and stall=0.
  - perf_full_cycles (32): increments on every cycle with iq_full=1.
- Both counters are saturating at 32'hFFFF_FFFF, reset by rst only, and not cleared by flushes.
- When undefined, these ports and counters do not exist. Functional behaviour is identical in both builds.

Decomposition:
- Shared header/package:
  - IQ_ENTRY_W = 65 (pc 32 + inst 32 + in_ds 1).
  - Entry field bit offsets.
  - ISSUE_NONE/ONE/TWO encodings (2'd0/1/2).
- One natural sub-module: inst_queue_ram, a DEPTH×IQ_ENTRY_W register file with 2 write ports (address, enable, data) and 2 asynchronous read ports. It has no reset.
- Pointer, count and flag logic stays in inst_queue.

Test Plan:
- Reset, then push slots 1 and 2 (pc 0xBFC00000/04, neither a branch) → next cycle iq_valid_1=iq_valid_2=1, pcs match, iq_count=2, in_ds=0/0.
- Push a branch at 0x100 (slot 1) and 0x104 (slot 2); next cycle push 0x108 alone → in_ds for 0x104=1, 0x108=0. Repeat with the branch as the last entry of a push → the following cycle's first entry has in_ds=1.
- Fill to count=15 with DEPTH=16 → iq_full=1; pushes are dropped with count held at 15. Pop 2 → iq_full=0 next cycle.
- Wrap-around: drive 40 cycles of push 2/pop 2 → FIFO order is preserved across pointer wrap; every pc sequence is checked.
- stall=1 with issue_num=2 and count=4 → no pop, count stays 4. Add flush=1 during stall → no effect. Drop stall with flush still 1 → count=0 next cycle.
- exception_flush=1 with stall=1, simultaneous push of 2 and issue_num=1 → count=0, iq_valid_1=0, last_wr_branch=0 next cycle. With INST_QUEUE_PERF_EN, perf counters are unchanged by the flush.
